// File: rtl/arb4_pkg.sv
// arb4_pkg: shared types and constants for the 4-way round-robin scheduler.
//   state_t              : FSM state encoding (IDLE, GRANT)
//   NUM_REQ              : number of requesters (4)
//   IDX_W                : width of a requester index (2)
//   DEF_TIMEOUT_CYCLES   : default maximum grant hold time in cycles
package arb4_pkg;

  localparam int NUM_REQ            = 4;
  localparam int IDX_W              = 2;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/arb4_scheduler_if.sv
// arb4_scheduler_if: request/grant bundle between requesters and the scheduler.
//   req     : per-requester request lines
//   done    : release strobe from the current grant holder
//   gnt     : one-hot grant
//   gnt_idx : binary index of the granted requester (0 when idle)
//   busy    : high while a grant is held
//   timeout : one-cycle pulse on a forced release
// Modports: master (requester side), slave (scheduler side).
interface arb4_scheduler_if;
  import arb4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               busy;
  logic               timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, busy, timeout
  );

endinterface

// File: rtl/arb4_rr_pick.sv
// arb4_rr_pick: combinational round-robin winner selection.
//   i_req    : request vector
//   i_ptr    : requester with highest priority this round
//   o_onehot : one-hot winner (all zero when no request)
//   o_idx    : binary winner index (0 when no request)
// The search starts at i_ptr and wraps modulo NUM_REQ.
module arb4_rr_pick
  import arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Index arithmetic wraps naturally in IDX_W bits.
      w_cand = i_ptr + IDX_W'(i);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb4_scheduler.sv
// arb4_scheduler: 4-requester round-robin arbiter for a shared datapath.
//   clk     : clock, rising edge active
//   rst_n   : asynchronous active-low reset
//   bus     : arb4_scheduler_if.slave (req, done in; gnt, gnt_idx, busy, timeout out)
// Parameter TIMEOUT_CYCLES (2..255): maximum GRANT cycles before forced release.
// Optional feature macro ARB4_SCHED_TIMEOUT_EN enables the hold counter and
// timeout pulse; without it timeout is tied low and a grant ends only via
// done, abort (holder drops its request) or reset.
// All outputs are registered; a release is always followed by one IDLE cycle.
module arb4_scheduler
  import arb4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  arb4_scheduler_if.slave   bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("arb4_scheduler: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t             r_state,   w_state_nxt;
  logic [IDX_W-1:0]   r_ptr,     w_ptr_nxt;
  logic [NUM_REQ-1:0] r_gnt,     w_gnt_nxt;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
  logic               r_busy,    w_busy_nxt;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_hold;
  logic               w_expire;

`ifdef ARB4_SCHED_TIMEOUT_EN
  logic [7:0] r_cnt,     w_cnt_nxt;
  logic       r_timeout, w_timeout_nxt;

  assign w_expire = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign w_expire = 1'b0;
`endif

  arb4_rr_pick u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  // Holder still requesting; a dropped request with no done is an abort.
  assign w_hold = bus.req[r_gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_busy    <= 1'b0;
`ifdef ARB4_SCHED_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_busy    <= w_busy_nxt;
`ifdef ARB4_SCHED_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = r_gnt;
    w_gnt_idx_nxt = r_gnt_idx;
    w_busy_nxt    = r_busy;
`ifdef ARB4_SCHED_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nxt   = GRANT;
          w_gnt_nxt     = w_pick_onehot;
          w_gnt_idx_nxt = w_pick_idx;
          w_busy_nxt    = 1'b1;
`ifdef ARB4_SCHED_TIMEOUT_EN
          w_cnt_nxt     = '0;
`endif
        end
      end
      GRANT: begin
        if (bus.done || !w_hold || w_expire) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_gnt_idx_nxt = '0;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = r_gnt_idx + IDX_W'(1);
`ifdef ARB4_SCHED_TIMEOUT_EN
          w_cnt_nxt     = '0;
          // Pulse only when expiry alone caused the release.
          w_timeout_nxt = w_expire && !bus.done && w_hold;
`endif
        end else begin
`ifdef ARB4_SCHED_TIMEOUT_EN
          w_cnt_nxt     = r_cnt + 8'd1;
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.busy    = r_busy;
`ifdef ARB4_SCHED_TIMEOUT_EN
  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb4_scheduler.sv
// tb_arb4_scheduler: self-checking bench for arb4_scheduler.
module tb_arb4_scheduler;
  import arb4_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [1:0] exp_q[$];

  arb4_scheduler_if bus();

  arb4_scheduler #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Independent reference for the round-robin choice.
  function automatic logic [1:0] model_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] c;
    for (int k = 0; k < 4; k++) begin
      c = p + 2'(k);
      if (r[c]) return c;
    end
    return 2'b00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    n_tests++;
    if ({bus.gnt, bus.gnt_idx, bus.busy, bus.timeout} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b idx=%b busy=%b to=%b, required all zero",
               bus.gnt, bus.gnt_idx, bus.busy, bus.timeout);
    end
    bus.req = 4'b0000;
    rst_n   = 1'b1;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got gnt=%b busy=%b, required gnt=0000 busy=0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_first_grant();
    do_reset();
    bus.req = 4'b1010;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0010 || bus.gnt_idx !== 2'b01 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: got gnt=%b idx=%b busy=%b, required 0010/01/1",
               bus.gnt, bus.gnt_idx, bus.busy);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt_idx !== 2'b00) begin
      n_fail++;
      $display("FAIL done_release: got gnt=%b idx=%b busy=%b, required 0000/00/0",
               bus.gnt, bus.gnt_idx, bus.busy);
    end
    // done while idle must not change anything
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_in_idle: got gnt=%b busy=%b, required 0000/0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] m_ptr;
    logic [1:0] e;
    do_reset();
    m_ptr   = 2'd0;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e = model_pick(bus.req, m_ptr);
      exp_q.push_back(e);
      m_ptr = e + 2'd1;
    end
    for (int g = 0; g < 5; g++) begin
      step();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
      n_tests++;
      if (bus.busy !== 1'b1 || bus.gnt_idx !== e || bus.gnt !== (4'b0001 << e)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got gnt=%b idx=%0d busy=%b, required idx=%0d busy=1",
                 g, bus.gnt, bus.gnt_idx, bus.busy, e);
      end
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      n_tests++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle%0d: got gnt=%b busy=%b, required 0000/0", g, bus.gnt, bus.busy);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_abort();
    do_reset();
    bus.req = 4'b0100;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0100 || bus.gnt_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL abort_setup: got gnt=%b idx=%0d, required 0100/2", bus.gnt, bus.gnt_idx);
    end
    // other requesters toggling must not disturb the held grant
    bus.req = 4'b1111;
    step();
    bus.req = 4'b0101;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0100 || bus.gnt_idx !== 2'd2 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL grant_hold: got gnt=%b idx=%0d busy=%b, required 0100/2/1",
               bus.gnt, bus.gnt_idx, bus.busy);
    end
    bus.req = 4'b0000;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: got gnt=%b busy=%b to=%b, required 0000/0/0",
               bus.gnt, bus.busy, bus.timeout);
    end
    bus.req = 4'b1111;
    step();
    n_tests++;
    if (bus.gnt !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL abort_next_ptr: got gnt=%b idx=%0d, required 1000/3", bus.gnt, bus.gnt_idx);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_done_with_req();
    do_reset();
    bus.req = 4'b1000;
    step();
    n_tests++;
    if (bus.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL same_cycle_setup: got gnt=%b, required 1000", bus.gnt);
    end
    bus.done = 1'b1;
    bus.req  = 4'b0001;
    step();
    bus.done = 1'b0;
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_release: got gnt=%b busy=%b, required 0000/0", bus.gnt, bus.busy);
    end
    step();
    n_tests++;
    if (bus.gnt !== 4'b0001 || bus.gnt_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL same_cycle_regrant: got gnt=%b idx=%0d, required 0001/0", bus.gnt, bus.gnt_idx);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    bus.req = 4'b0010;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_setup: got gnt=%b, required 0010", bus.gnt);
    end
`ifdef ARB4_SCHED_TIMEOUT_EN
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL to_hold: got %0d bad cycles, required 0", bad);
    end
    step();
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_release: got gnt=%b busy=%b to=%b, required 0000/0/1",
               bus.gnt, bus.busy, bus.timeout);
    end
    step();
    n_tests++;
    if (bus.timeout !== 1'b0 || bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_pulse_width: got to=%b gnt=%b, required 0/0010", bus.timeout, bus.gnt);
    end
    // done coinciding with expiry counts as done
    step();
    step();
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done_coincide: got gnt=%b to=%b, required 0000/0", bus.gnt, bus.timeout);
    end
`else
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1 || bus.timeout !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_timeout_hold: got %0d bad cycles, required 0", bad);
    end
`endif
    bus.req = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0100;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL areset_setup: got gnt=%b, required 0100", bus.gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt_idx !== 2'b00 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got gnt=%b idx=%b busy=%b to=%b, required all zero",
               bus.gnt, bus.gnt_idx, bus.busy, bus.timeout);
    end
    #1;
    bus.req = 4'b0000;
    rst_n   = 1'b1;
    bus.req = 4'b1000;
    step();
    n_tests++;
    if (bus.gnt !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL areset_regrant: got gnt=%b idx=%0d, required 1000/3", bus.gnt, bus.gnt_idx);
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_abort();
    test_done_with_req();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
